// File: rtl/aes_sbox_pkg.sv
// AES S-box tables and lookup helpers shared by the SubBytes engine.
// Tables are indexed by the input byte; element 0 is listed first.
package aes_sbox_pkg;

   typedef logic [7:0] byte_t;

   localparam byte_t SBOX_FWD [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam byte_t SBOX_INV [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic byte_t sbox_fwd(input byte_t b);
      return SBOX_FWD[b];
   endfunction

   function automatic byte_t sbox_inv(input byte_t b);
      return SBOX_INV[b];
   endfunction

endpackage

// File: rtl/sbox_lane_dual.sv
// One byte lane: combinational forward/inverse S-box select.
module sbox_lane_dual
   import aes_sbox_pkg::*;
(
   input  logic [7:0] in_byte,
   input  logic       inv,
   output logic [7:0] out_byte
);

   always_comb begin
      out_byte = inv ? sbox_inv(in_byte) : sbox_fwd(in_byte);
   end

endmodule

// File: rtl/sbox_subbytes_pipe.sv
// Multi-lane SubBytes engine with 1 or 2 registered stages and valid/ready flow control.
// The lookup sits before stage 0 (1 stage) or between stage 0 and stage 1 (2 stages).
module sbox_subbytes_pipe
   import aes_sbox_pkg::*;
#(
   parameter int N_BYTES     = 16,
   parameter int PIPE_STAGES = 1,
   parameter int INV_EN      = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [8*N_BYTES-1:0] in_data,
   input  logic                 in_inv,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*N_BYTES-1:0] out_data,
   output logic                 out_inv,
   output logic                 busy
);

   localparam int DW   = 8*N_BYTES;
   localparam int LAST = PIPE_STAGES-1;

   logic [PIPE_STAGES-1:0]         vld_q, vld_d;
   logic [PIPE_STAGES-1:0][DW-1:0] data_q, data_d;
   logic [PIPE_STAGES-1:0]         inv_q, inv_d;

   logic          mode_in;
   logic          adv_last, adv_0;
   logic [DW-1:0] lut_in, lut_out;
   logic          lut_inv;

   assign mode_in = (INV_EN != 0) ? in_inv : 1'b0;

   // A stage may load when empty or when its occupant leaves this cycle;
   // for one stage adv_0 reduces to adv_last.
   assign adv_last = !vld_q[LAST] || out_ready;
   assign adv_0    = !vld_q[0] || adv_last;

   generate
      if (PIPE_STAGES == 1) begin : g_lut_comb_in
         assign lut_in  = in_data;
         assign lut_inv = mode_in;
      end else begin : g_lut_reg_in
         assign lut_in  = data_q[0];
         assign lut_inv = inv_q[0];
      end
   endgenerate

   generate
      for (genvar i = 0; i < N_BYTES; i++) begin : g_lane
         sbox_lane_dual u_lane (
            .in_byte  (lut_in[8*i +: 8]),
            .inv      (lut_inv),
            .out_byte (lut_out[8*i +: 8])
         );
      end
   endgenerate

   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      inv_d  = inv_q;
      if (adv_0) begin
         vld_d[0] = in_valid;
         if (in_valid) begin
            data_d[0] = (PIPE_STAGES == 1) ? lut_out : in_data;
            inv_d[0]  = mode_in;
         end
      end
      if (PIPE_STAGES > 1 && adv_last) begin
         vld_d[LAST] = vld_q[0];
         if (vld_q[0]) begin
            data_d[LAST] = lut_out;
            inv_d[LAST]  = inv_q[0];
         end
      end
   end

   // Only the valid bits are reset; payload is qualified by them.
   always_ff @(posedge clk) begin
      if (!rst_n) vld_q <= '0;
      else        vld_q <= vld_d;
      data_q <= data_d;
      inv_q  <= inv_d;
   end

   assign in_ready  = adv_0;
   assign out_valid = vld_q[LAST];
   assign out_data  = data_q[LAST];
   assign out_inv   = inv_q[LAST];
   assign busy      = |vld_q;

endmodule

// File: tb/tb_sbox_subbytes_pipe.sv
// Bench for sbox_subbytes_pipe: known-answer table plus scoreboard-driven stream tests.
// The reference S-box is rebuilt from GF(2^8) inversion and the affine map.
module tb_sbox_subbytes_pipe;

   localparam int NB = 16;
   localparam int P  = 2;
   localparam int DW = 8*NB;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_inv;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_inv;
   logic          busy;

   sbox_subbytes_pipe #(.N_BYTES(NB), .PIPE_STAGES(P), .INV_EN(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_inv    (in_inv),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_inv   (out_inv),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [7:0] fwd_t [256];
   logic [7:0] inv_t [256];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p = p ^ a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8-n));
   endfunction

   function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic inv);
      logic [DW-1:0] r;
      for (int l = 0; l < NB; l++)
         r[8*l +: 8] = inv ? inv_t[d[8*l +: 8]] : fwd_t[d[8*l +: 8]];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [DW:0] beat;   // {inv, data}
   } sb_t;

   sb_t           sb_q [$];
   logic [DW-1:0] out_log [$];
   int            cyc = 0;
   int            out_cnt = 0;
   int            last_out_cyc = 0;
   bit            hold_v = 1'b0;
   logic [DW-1:0] hold_d;
   logic          hold_i;

   // Monitor: push expected on input transfer, pop and compare on output transfer.
   always @(negedge clk) begin
      sb_t e;
      cyc++;
      if (!rst_n) begin
         sb_q.delete();
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            checks++;
            if (!out_valid || out_data !== hold_d || out_inv !== hold_i) begin
               failures++;
               $display("FAIL hold_stable: got v=%0b d=%h i=%0b expected v=1 d=%h i=%0b",
                        out_valid, out_data, out_inv, hold_d, hold_i);
            end
         end
         hold_v = out_valid && !out_ready;
         hold_d = out_data;
         hold_i = out_inv;
         if (out_valid && out_ready) begin
            out_log.push_back(out_data);
            out_cnt++;
            last_out_cyc = cyc;
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL sb_underflow: got unexpected beat %h expected none", out_data);
            end else begin
               e = sb_q.pop_front();
               if ({out_inv, out_data} !== e.beat) begin
                  failures++;
                  $display("FAIL sb_compare: got %h expected %h", {out_inv, out_data}, e.beat);
               end
            end
         end
         if (in_valid && in_ready) begin
            e.beat = {in_inv, model(in_data, in_inv)};
            sb_q.push_back(e);
         end
      end
   end

   task automatic send(input logic [DW-1:0] d, input logic inv);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_inv   = inv;
      for (int c = 0; c < 40 && !ok; c++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL send_timeout: got in_ready=0 for 40 cycles expected accept");
      end
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         lat++;
         if (out_valid) return;
      end
      checks++;
      failures++;
      $display("FAIL wait_out_timeout: got out_valid=0 expected 1 within 20 cycles");
   endtask

   typedef struct {
      logic [DW-1:0] din;
      logic          inv;
      logic [DW-1:0] dexp;
      logic          iexp;
   } vec_t;

   vec_t vt [6];

   initial begin : wdog
      #400000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int            lat, start, lows, base;
      logic [DW-1:0] orig [16];
      logic [DW-1:0] sub  [16];
      logic [DW-1:0] r;

      // Reference tables from field inversion + affine transform.
      for (int x = 0; x < 256; x++) begin
         logic [7:0] iv, s;
         iv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(x[7:0], y[7:0]) == 8'h01) iv = y[7:0];
         s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
         fwd_t[x] = s;
         inv_t[s] = x[7:0];
      end

      vt[0] = '{128'h0f0e0d0c0b0a09080706050403020100, 1'b0, 128'h76abd7fe2b670130c56f6bf27b777c63, 1'b0};
      vt[1] = '{{16{8'h53}}, 1'b0, {16{8'hed}}, 1'b0};
      vt[2] = '{{16{8'hed}}, 1'b1, {16{8'h53}}, 1'b1};
      vt[3] = '{{16{8'hff}}, 1'b0, {16{8'h16}}, 1'b0};
      vt[4] = '{{16{8'h16}}, 1'b1, {16{8'hff}}, 1'b1};
      vt[5] = '{{16{8'h00}}, 1'b0, {16{8'h63}}, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // Known-answer table, one beat at a time.
      foreach (vt[i]) begin
         send(vt[i].din, vt[i].inv);
         wait_out(lat);
         chk($sformatf("kat%0d_latency", i), lat, P);
         chk($sformatf("kat%0d_data", i), out_data, vt[i].dexp);
         chk($sformatf("kat%0d_inv", i), out_inv, vt[i].iexp);
         @(posedge clk); #1;
      end

      // Back-to-back mode switch.
      send({16{8'h53}}, 1'b0);
      send({16{8'hed}}, 1'b1);
      wait_out(lat);
      chk("mode_a_data", out_data, {16{8'hed}});
      chk("mode_a_inv", out_inv, 0);
      @(negedge clk);
      chk("mode_b_valid", out_valid, 1);
      chk("mode_b_data", out_data, {16{8'h53}});
      chk("mode_b_inv", out_inv, 1);
      repeat (4) @(posedge clk); #1;

      // Round trip over all 256 byte values.
      out_log.delete();
      for (int b = 0; b < 16; b++) begin
         for (int l = 0; l < NB; l++) orig[b][8*l +: 8] = 8'(16*b + l);
         send(orig[b], 1'b0);
      end
      for (int c = 0; c < 40 && out_log.size() < 16; c++) @(negedge clk);
      chk("rt_fwd_count", out_log.size(), 16);
      for (int b = 0; b < 16; b++) sub[b] = (out_log.size() > 0) ? out_log.pop_front() : '0;
      @(posedge clk); #1;
      for (int b = 0; b < 16; b++) send(sub[b], 1'b1);
      for (int c = 0; c < 40 && out_log.size() < 16; c++) @(negedge clk);
      chk("rt_inv_count", out_log.size(), 16);
      for (int b = 0; b < 16; b++) begin
         r = (out_log.size() > 0) ? out_log.pop_front() : '0;
         chk($sformatf("rt_beat%0d", b), r, orig[b]);
      end
      @(posedge clk); #1;

      // Backpressure: pipeline fills, third beat held off.
      out_ready = 1'b0;
      for (int b = 0; b < P; b++) send({16{8'(8'h20 + b)}}, b[0]);
      in_valid = 1'b1; in_data = {16{8'h7e}}; in_inv = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("bp_in_ready_low%0d", c), in_ready, 0);
         chk($sformatf("bp_out_valid%0d", c), out_valid, 1);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_release", in_ready, 1);
      @(posedge clk); #1 in_valid = 1'b0;
      for (int c = 0; c < 20 && (sb_q.size() != 0 || busy); c++) @(negedge clk);
      chk("bp_drained", sb_q.size(), 0);
      @(posedge clk); #1;

      // Throughput with continuous valid/ready.
      start = cyc; lows = 0; base = out_cnt;
      for (int k = 0; k < 100; k++) begin
         in_valid = 1'b1;
         in_data  = {$urandom, $urandom, $urandom, $urandom};
         in_inv   = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (!in_ready) lows++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      for (int c = 0; c < 20 && out_cnt - base < 100; c++) @(negedge clk);
      chk("tp_in_ready_lows", lows, 0);
      chk("tp_out_count", out_cnt - base, 100);
      checks++;
      if (last_out_cyc - start > 100 + P) begin
         failures++;
         $display("FAIL tp_cycles: got %0d expected <= %0d", last_out_cyc - start, 100 + P);
      end
      @(posedge clk); #1;

      // Reset with a full, stalled pipeline.
      out_ready = 1'b0;
      for (int b = 0; b < P; b++) send({16{8'(8'h40 + b)}}, 1'b0);
      in_valid = 1'b1; in_data = {16{8'h99}}; in_inv = 1'b0;
      @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_out_valid", out_valid, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_in_ready", in_ready, 1);
      @(posedge clk); #1 out_ready = 1'b1;
      send({16{8'h00}}, 1'b0);
      wait_out(lat);
      chk("rst_post_latency", lat, P);
      chk("rst_post_data", out_data, {16{8'h63}});
      repeat (3) @(posedge clk);
      chk("final_sb_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sbox_subbytes_pipe.md
Name: sbox_subbytes_pipe

Overview:
Parametrised, pipelined multi-lane SubBytes engine. Applies the AES S-box, or its inverse, to N_BYTES independent bytes per beat. Uses a valid/ready handshake, so the hash datapath can stall it without losing data. Successor to the single-byte combinational lookup: it adds lane count, an inverse mode, registered pipeline stages and flow control.

Parameters:
N_BYTES, 16, number of byte lanes per beat (1..32); data width is 8*N_BYTES.
PIPE_STAGES, 1, number of registered stages between input and output (1 or 2).
INV_EN, 1, 1 = inverse S-box is selectable; 0 = in_inv is ignored and forward is always used.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  engine can accept a beat this cycle
in_data  input  8*N_BYTES  lane i = in_data[8i+7:8i]
in_inv  input  1  per-beat mode: 0 = forward S-box, 1 = inverse S-box
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts the beat
out_data  output  8*N_BYTES  substituted bytes, same lane order
out_inv  output  1  mode the beat was processed with
busy  output  1  at least one stage holds a valid beat

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-low (rst_n sampled on the rising clk edge).
  - On reset, every stage valid bit clears, so out_valid=0 and busy=0.
  - Data registers are not reset; out_data and out_inv are don't-care while out_valid=0. The bench checks them only under out_valid.
- Handshake:
  - A transfer occurs when valid & ready are both high on a clock edge.
  - out_valid, once asserted, stays high and out_data/out_inv stay stable until out_ready is sampled high.
  - in_ready does not depend combinationally on in_valid.
- Pipeline, stages s = 0..PIPE_STAGES-1, last stage drives the outputs:
  - Each stage advances when its own valid is low, or the next stage advances. For the last stage, "next stage advances" means out_ready.
  - in_ready = stage-0 advance condition. This collapses bubbles: no dead cycles when downstream is ready.
  - PIPE_STAGES=1: lookup is done on in_data and registered into stage 0.
  - PIPE_STAGES=2: stage 0 registers the raw input and mode; the lookup sits between stage 0 and stage 1.
  - Latency = PIPE_STAGES cycles from input transfer to out_valid (no stalls).
  - Throughput = 1 beat/cycle with out_ready held high.
- Mode:
  - in_inv is sampled with its beat and travels with it.
  - Back-to-back beats may alternate modes with no penalty.
  - When INV_EN=0, in_inv is ignored, out_inv=0, and the forward table is used.
- Lookup:
  - Purely combinational per lane. Lanes are independent: no carries, no cross-lane mixing.
  - Forward table is the standard AES S-box. Inverse table is its exact inverse: InvS(S(x)) = x for all 256 x.
- Boundary conditions:
  - Full pipeline with out_ready=0: in_ready=0, and the held input beat is not consumed.
  - Simultaneous output transfer and input transfer when full: accepted in the same cycle, nothing lost or duplicated.
  - Reset asserted mid-stream: all in-flight beats are discarded. The first cycle after release has out_valid=0 and in_ready=1.
  - in_valid=0: no stage loads a new beat; existing beats still drain.

Decomposition:
- Package aes_sbox_pkg:
  - constant arrays SBOX_FWD[256] and SBOX_INV[256] of 8-bit values;
  - functions sbox_fwd(byte) and sbox_inv(byte);
  - typedef byte_t.
- Sub-module sbox_lane_dual (8-bit in, inv select, 8-bit out, combinational): instantiated N_BYTES times via generate.
- Top level contains only the stage registers and handshake logic.

Test Plan:
1. Forward known-answer. N_BYTES=16, in_data lanes 0..15 = 00..0f, in_inv=0, out_ready=1 → after PIPE_STAGES cycles, lanes = 63 7c 77 7b f2 6b 6f c5 30 01 67 2b fe d7 ab 76, with out_inv=0.
2. Inverse and mode switching. Beat A lanes all 53 (fwd), then beat B lanes all ed (inv), back-to-back → A out = all ed, B out = all 53. out_inv = 0 then 1, on consecutive cycles.
3. Exhaustive round-trip. Stream all 256 byte values (16 beats) forward, feed the outputs back with in_inv=1 → recovered bytes equal the originals. Also check S(ff)=16 and InvS(16)=ff.
4. Backpressure. Send 3 beats with out_ready=0 → in_ready drops after PIPE_STAGES beats accepted; out_data is held stable. Raise out_ready → beats emerge in order, no loss or duplication. Check via scoreboard.
5. Throughput. 100 random beats with in_valid=1 and out_ready=1 continuously → 100 outputs in 100+PIPE_STAGES cycles, in_ready never low.
6. Reset mid-operation. Pipeline full with out_ready=0, pulse rst_n=0 for one cycle → next cycle out_valid=0, busy=0, in_ready=1. A new beat 00.. then gives 63.. with nominal latency.
